trace_capture_buffer: RTL and testbench

Instruction-trace capture stage that sits directly downstream of the processor top level. It samples the processor's observed program counter, fetched instruction word and zero flag every clock. Each time the program counter changes it pushes one trace entry into an internal FIFO. A valid/ready read port drains the FIFO toward a debug or host consumer, and the block also flags FIFO overflow and a processor-halt condition (program counter stuck).

---
 rtl/trace_capture_buffer.sv | 73 +++++++
 tb/tb_trace_capture_buffer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer: captures {pc, instr, z} on every PC change into a FIFO drained over valid/ready,
// with sticky overflow, saturating drop counter and PC-stuck halt detection.
module trace_capture_buffer #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int HALT_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       instr_in,
  input  logic              z_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic              out_z,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [15:0]       drop_cnt,
  output logic              halted
);
  logic [ADDR_W:0] wr_ptr, rd_ptr;
  logic [64:0]     mem [DEPTH];
  logic [31:0]     last_pc;
  logic            armed;
  logic [7:0]      halt_cnt;
  logic            cap, pop, full, push, stall;

  assign cap       = en && (!armed || pc_in != last_pc);
  assign count     = wr_ptr - rd_ptr;
  assign out_valid = count != '0;
  assign full      = (wr_ptr ^ rd_ptr) == {1'b1, {ADDR_W{1'b0}}};
  assign pop       = out_valid && out_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push      = cap && (!full || pop);
  assign stall     = en && armed && pc_in == last_pc && halt_cnt != 8'(HALT_CYCLES);
  assign halted    = halt_cnt == 8'(HALT_CYCLES);
  assign {out_pc, out_instr, out_z} = out_valid ? mem[rd_ptr[ADDR_W-1:0]] : '0;

  always_ff @(posedge clk)
    if (push && !clr) mem[wr_ptr[ADDR_W-1:0]] <= {pc_in, instr_in, z_in};

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_pc  <= '0;
      armed    <= 1'b0;
      halt_cnt <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      armed    <= 1'b0;
      halt_cnt <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (cap && !push) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
      if (cap) last_pc <= pc_in;
      armed    <= en;
      halt_cnt <= cap ? '0 : (stall ? halt_cnt + 1'b1 : halt_cnt);
    end
endmodule

// File: tb/tb_trace_capture_buffer.sv
// tb_trace_capture_buffer: directed and random traffic against a queue-based trace model with a negedge scoreboard monitor.
module tb_trace_capture_buffer;
  localparam int DEPTH = 16;
  localparam int HC    = 8;

  logic        clk = 0, rst = 0, en = 0, clr = 0, z_in = 0, out_ready = 0;
  logic [31:0] pc_in = 0, instr_in = 0;
  logic        out_valid, out_z, overflow, halted;
  logic [31:0] out_pc, out_instr;
  logic [4:0]  count;
  logic [15:0] drop_cnt;

  trace_capture_buffer #(.DEPTH(DEPTH), .ADDR_W(4), .HALT_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .pc_in(pc_in), .instr_in(instr_in), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_z(out_z),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [64:0] exp_q[$];
  int mcount = 0, hcnt = 0, mdrop = 0;
  bit ovf = 0, armed = 0;
  logic [31:0] last = 0;

  task automatic chk(input string n, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mcount = 0; hcnt = 0; mdrop = 0; ovf = 0; armed = 0; last = 0;
  endtask

  // scoreboard monitor: state settled after the previous edge, inputs for the next edge already applied
  always @(negedge clk) if (rst) begin
    chk("count", 65'(count), 65'(mcount));
    chk("out_valid", 65'(out_valid), 65'(mcount != 0));
    chk("overflow", 65'(overflow), 65'(ovf));
    chk("drop_cnt", 65'(drop_cnt), 65'(mdrop));
    chk("halted", 65'(halted), 65'(hcnt == HC));
    if (out_valid) begin
      if (exp_q.size() == 0) chk("head_present", 65'(0), 65'(1));
      else begin
        chk("head", {out_pc, out_instr, out_z}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic e, input logic c, input logic r, input logic [31:0] p);
    logic [31:0] ins;
    logic zz;
    bit pop, cap;
    ins = $urandom;
    zz = 1'($urandom_range(0, 1));
    en = e; clr = c; out_ready = r; pc_in = p; instr_in = ins; z_in = zz;
    @(posedge clk);
    pop = mcount > 0 && r;
    if (c) begin
      exp_q.delete();
      mcount = 0; hcnt = 0; mdrop = 0; ovf = 0; armed = 0;
    end else begin
      cap = e && (!armed || p != last);
      if (cap) begin
        if (mcount < DEPTH || pop) begin
          exp_q.push_back({p, ins, zz});
          mcount++;
        end else begin
          ovf = 1;
          if (mdrop < 65535) mdrop++;
        end
        last = p; hcnt = 0;
      end else if (e && armed && p == last && hcnt < HC) hcnt++;
      armed = e;
      if (pop) mcount--;
    end
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1;
    // order
    step(1, 0, 0, 32'h0); step(1, 0, 0, 32'h4); step(1, 0, 0, 32'h8);
    chk("order_count", 65'(count), 65'd3);
    chk("order_head0", 65'(out_pc), 65'h0);
    step(1, 0, 1, 32'h8);
    chk("order_head1", 65'(out_pc), 65'h4);
    step(1, 0, 1, 32'h8);
    chk("order_head2", 65'(out_pc), 65'h8);
    step(1, 0, 1, 32'h8);
    chk("order_empty", 65'(out_valid), 65'd0);
    // overflow
    step(1, 1, 0, 32'h0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 32'h100 + 32'(4 * i));
    chk("ovf_count", 65'(count), 65'd16);
    chk("ovf_flag", 65'(overflow), 65'd1);
    chk("ovf_drop", 65'(drop_cnt), 65'd4);
    chk("ovf_head", 65'(out_pc), 65'h100);
    step(1, 0, 1, 32'h1000);
    chk("ovf_pp_drop", 65'(drop_cnt), 65'd4);
    chk("ovf_pp_count", 65'(count), 65'd16);
    // full push + pop
    step(1, 1, 0, 32'h0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 32'h300 + 32'(4 * i));
    chk("full_count", 65'(count), 65'd16);
    step(1, 0, 1, 32'h400);
    chk("fpp_count", 65'(count), 65'd16);
    chk("fpp_ovf", 65'(overflow), 65'd0);
    chk("fpp_head", 65'(out_pc), 65'h304);
    // halt
    step(1, 1, 0, 32'h20);
    step(1, 0, 0, 32'h20);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 32'h20);
    chk("halt_7", 65'(halted), 65'd0);
    step(1, 0, 0, 32'h20);
    chk("halt_8", 65'(halted), 65'd1);
    step(1, 0, 0, 32'h24);
    chk("halt_release", 65'(halted), 65'd0);
    chk("halt_count", 65'(count), 65'd2);
    // clear and re-arm
    step(1, 1, 0, 32'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 32'h200 + 32'(4 * i));
    chk("clr_pre", 65'(count), 65'd5);
    step(1, 1, 0, 32'h210);
    chk("clr_count", 65'(count), 65'd0);
    chk("clr_drop", 65'(drop_cnt), 65'd0);
    step(1, 0, 0, 32'h210);
    chk("rearm_clr", 65'(count), 65'd1);
    step(0, 0, 0, 32'h210);
    step(1, 0, 0, 32'h210);
    chk("rearm_en", 65'(count), 65'd2);
    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)),
           32'(4 * $urandom_range(0, 5)));
    // asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h500 + 32'(4 * i));
    #2 rst = 0;
    #1;
    chk("rst_valid", 65'(out_valid), 65'd0);
    chk("rst_count", 65'(count), 65'd0);
    chk("rst_ovf", 65'(overflow), 65'd0);
    chk("rst_drop", 65'(drop_cnt), 65'd0);
    chk("rst_halted", 65'(halted), 65'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1;
    step(1, 0, 0, 32'h0);
    chk("post_rst_capture", 65'(count), 65'd1);
    step(1, 0, 1, 32'h0);
    step(1, 0, 1, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
